// File: rtl/operand_loader.sv
//==============================================================================
// Module      : operand_loader
// Description : Byte-wide operand sequencer; stages a 4-byte frame and commits
//               it atomically with a one-cycle load strobe. Optional mid-frame
//               idle timeout enabled by OPERAND_LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module operand_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       frame_clear,
    output logic [2:0] sel_out,
    output logic [7:0] register_2_lsb,
    output logic [7:0] register_2_msb,
    output logic [7:0] counter_value,
    output logic       counter_carry,
    output logic       load_strobe,
    output logic       frame_error
);

    // Field codes shared with the output mux
    localparam logic [2:0] MUX_SEL_REGISTER_2_LSB = 3'd0;
    localparam logic [2:0] MUX_SEL_REGISTER_2_MSB = 3'd1;
    localparam logic [2:0] MUX_SEL_COUNTER_VALUE  = 3'd2;
    localparam logic [2:0] MUX_SEL_COUNTER_CARRY  = 3'd3;

    typedef enum logic [2:0] {
        S_LSB    = 3'd0,
        S_MSB    = 3'd1,
        S_CNT    = 3'd2,
        S_CARRY  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] stg_lsb_q, stg_lsb_d;
    logic [7:0] stg_msb_q, stg_msb_d;
    logic [7:0] stg_cnt_q, stg_cnt_d;
    logic       err_q, err_d;
    logic       w_xfer;
    logic       w_commit;

`ifdef OPERAND_LOADER_TIMEOUT_EN
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);
    logic [7:0] idle_q, idle_d;
    logic       w_mid_frame;
`endif

    assign byte_ready  = (state_q != S_COMMIT) && !frame_clear;
    assign w_xfer      = byte_valid && byte_ready;
    assign load_strobe = (state_q == S_COMMIT);
    assign frame_error = err_q;

    always_comb begin
        state_d   = state_q;
        stg_lsb_d = stg_lsb_q;
        stg_msb_d = stg_msb_q;
        stg_cnt_d = stg_cnt_q;
        err_d     = 1'b0;
        w_commit  = 1'b0;
        sel_out   = MUX_SEL_REGISTER_2_LSB;

        case (state_q)
            S_MSB:    sel_out = MUX_SEL_REGISTER_2_MSB;
            S_CNT:    sel_out = MUX_SEL_COUNTER_VALUE;
            S_CARRY,
            S_COMMIT: sel_out = MUX_SEL_COUNTER_CARRY;
            default:  sel_out = MUX_SEL_REGISTER_2_LSB;
        endcase

        if (state_q == S_COMMIT) begin
            state_d = S_LSB;
        end else if (frame_clear) begin
            state_d = S_LSB;
        end else if (w_xfer) begin
            case (state_q)
                S_LSB: begin
                    stg_lsb_d = byte_in;
                    state_d   = S_MSB;
                end
                S_MSB: begin
                    stg_msb_d = byte_in;
                    state_d   = S_CNT;
                end
                S_CNT: begin
                    stg_cnt_d = byte_in;
                    state_d   = S_CARRY;
                end
                default: begin
                    // Carry byte must be 0 or 1; anything else poisons the frame
                    if (byte_in[7:1] == 7'd0) begin
                        w_commit = 1'b1;
                        state_d  = S_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_LSB;
                    end
                end
            endcase
        end

`ifdef OPERAND_LOADER_TIMEOUT_EN
        w_mid_frame = (state_q == S_MSB) || (state_q == S_CNT) || (state_q == S_CARRY);
        idle_d      = idle_q;
        if (w_mid_frame && !frame_clear && !w_xfer) begin
            if (idle_q == C_TIMEOUT - 8'd1) begin
                err_d   = 1'b1;
                state_d = S_LSB;
            end else begin
                idle_d = idle_q + 8'd1;
            end
        end
        if (w_xfer || state_d == S_LSB) begin
            idle_d = 8'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_LSB;
            stg_lsb_q      <= 8'd0;
            stg_msb_q      <= 8'd0;
            stg_cnt_q      <= 8'd0;
            err_q          <= 1'b0;
            register_2_lsb <= 8'd0;
            register_2_msb <= 8'd0;
            counter_value  <= 8'd0;
            counter_carry  <= 1'b0;
        end else begin
            state_q   <= state_d;
            stg_lsb_q <= stg_lsb_d;
            stg_msb_q <= stg_msb_d;
            stg_cnt_q <= stg_cnt_d;
            err_q     <= err_d;
            if (w_commit) begin
                register_2_lsb <= stg_lsb_q;
                register_2_msb <= stg_msb_q;
                counter_value  <= stg_cnt_q;
                counter_carry  <= byte_in[0];
            end
        end
    end

`ifdef OPERAND_LOADER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= 8'd0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
//==============================================================================
// Module      : tb_operand_loader
// Description : Directed self-checking bench for operand_loader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_operand_loader;

    localparam logic [2:0] SEL_LSB = 3'd0;
    localparam logic [2:0] SEL_MSB = 3'd1;
    localparam logic [2:0] SEL_CNT = 3'd2;
    localparam logic [2:0] SEL_CAR = 3'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_clear;
    logic [2:0] sel_out;
    logic [7:0] register_2_lsb;
    logic [7:0] register_2_msb;
    logic [7:0] counter_value;
    logic       counter_carry;
    logic       load_strobe;
    logic       frame_error;

    // Values sampled mid-cycle by cyc()
    logic       s_ready, s_strobe, s_err, s_carry;
    logic [2:0] s_sel;
    logic [7:0] s_lsb, s_msb, s_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    operand_loader #(
`ifdef OPERAND_LOADER_TIMEOUT_EN
        .TIMEOUT_CYCLES(4)
`else
        .TIMEOUT_CYCLES(16)
`endif
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .byte_ready     (byte_ready),
        .frame_clear    (frame_clear),
        .sel_out        (sel_out),
        .register_2_lsb (register_2_lsb),
        .register_2_msb (register_2_msb),
        .counter_value  (counter_value),
        .counter_carry  (counter_carry),
        .load_strobe    (load_strobe),
        .frame_error    (frame_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample at the falling edge, return just after the rising edge
    task automatic cyc(input logic v, input logic [7:0] d, input logic clr);
        byte_valid  = v;
        byte_in     = d;
        frame_clear = clr;
        @(negedge clk);
        s_ready  = byte_ready;
        s_strobe = load_strobe;
        s_err    = frame_error;
        s_sel    = sel_out;
        s_lsb    = register_2_lsb;
        s_msb    = register_2_msb;
        s_cnt    = counter_value;
        s_carry  = counter_carry;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] l, input logic [7:0] m,
                              input logic [7:0] c, input logic k);
        check({tag, ".lsb"}, 32'(s_lsb), 32'(l));
        check({tag, ".msb"}, 32'(s_msb), 32'(m));
        check({tag, ".cnt"}, 32'(s_cnt), 32'(c));
        check({tag, ".carry"}, 32'(s_carry), 32'(k));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] f1 [4];
        logic [7:0] f2 [8];
        logic [7:0] thr [4];
        logic [2:0] sels [4];
        int strobes;

        reset       = 1'b1;
        byte_in     = 8'h00;
        byte_valid  = 1'b0;
        frame_clear = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        cyc(1'b0, 8'h00, 1'b0);
        check("rst.sel", 32'(s_sel), 32'(SEL_LSB));
        check("rst.ready", 32'(s_ready), 32'd1);
        check("rst.strobe", 32'(s_strobe), 32'd0);
        check("rst.err", 32'(s_err), 32'd0);
        check_outs("rst", 8'h00, 8'h00, 8'h00, 1'b0);

        // Single frame 34 12 7F 01
        f1 = '{8'h34, 8'h12, 8'h7F, 8'h01};
        sels = '{SEL_LSB, SEL_MSB, SEL_CNT, SEL_CAR};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, f1[i], 1'b0);
            check($sformatf("f1.sel%0d", i), 32'(s_sel), 32'(sels[i]));
            check($sformatf("f1.ready%0d", i), 32'(s_ready), 32'd1);
            check($sformatf("f1.strobe%0d", i), 32'(s_strobe), 32'd0);
        end
        cyc(1'b0, 8'h00, 1'b0);
        check("f1.c5.strobe", 32'(s_strobe), 32'd1);
        check("f1.c5.ready", 32'(s_ready), 32'd0);
        check("f1.c5.sel", 32'(s_sel), 32'(SEL_CAR));
        check_outs("f1", 8'h34, 8'h12, 8'h7F, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        check("f1.c6.strobe", 32'(s_strobe), 32'd0);
        check("f1.c6.sel", 32'(s_sel), 32'(SEL_LSB));

        // Two frames with byte_valid held; byte 0x01 held through the commit cycle
        f2 = '{8'hAA, 8'h55, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h01};
        strobes = 0;
        for (int i = 0; i < 4; i++) cyc(1'b1, f2[i], 1'b0);
        cyc(1'b1, f2[4], 1'b0);
        check("f2a.strobe", 32'(s_strobe), 32'd1);
        check("f2a.ready", 32'(s_ready), 32'd0);
        check_outs("f2a", 8'hAA, 8'h55, 8'h10, 1'b0);
        for (int i = 4; i < 8; i++) begin
            cyc(1'b1, f2[i], 1'b0);
            if (s_strobe) strobes++;
        end
        cyc(1'b0, 8'h00, 1'b0);
        check("f2b.strobe", 32'(s_strobe), 32'd1);
        check("f2b.extra_strobes", 32'(strobes), 32'd0);
        check_outs("f2b", 8'h01, 8'h02, 8'h03, 1'b1);

        // Bad carry byte 0x02
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        check("bad.err_early", 32'(s_err), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        check("bad.err", 32'(s_err), 32'd1);
        check("bad.strobe", 32'(s_strobe), 32'd0);
        check("bad.sel", 32'(s_sel), 32'(SEL_LSB));
        check("bad.ready", 32'(s_ready), 32'd1);
        check_outs("bad", 8'h01, 8'h02, 8'h03, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        check("bad.err_once", 32'(s_err), 32'd0);

        // Carry byte with only bit 7 set is also rejected
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        cyc(1'b1, 8'h03, 1'b0);
        cyc(1'b1, 8'h80, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("bad80.err", 32'(s_err), 32'd1);
        check("bad80.strobe", 32'(s_strobe), 32'd0);

        // frame_clear in S_CNT together with byte_valid
        cyc(1'b1, 8'h44, 1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b1, 8'h66, 1'b1);
        check("clr.sel", 32'(s_sel), 32'(SEL_CNT));
        check("clr.ready", 32'(s_ready), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        check("clr.sel_after", 32'(s_sel), 32'(SEL_LSB));
        check("clr.err", 32'(s_err), 32'd0);
        check_outs("clr", 8'h01, 8'h02, 8'h03, 1'b1);
        cyc(1'b1, 8'h9A, 1'b0);
        cyc(1'b1, 8'hBC, 1'b0);
        cyc(1'b1, 8'hDE, 1'b0);
        cyc(1'b1, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("clr.post.strobe", 32'(s_strobe), 32'd1);
        check_outs("clr.post", 8'h9A, 8'hBC, 8'hDE, 1'b0);

        // frame_clear during S_COMMIT is ignored
        cyc(1'b1, 8'h0F, 1'b0);
        cyc(1'b1, 8'hF0, 1'b0);
        cyc(1'b1, 8'h3C, 1'b0);
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        check("clrc.strobe", 32'(s_strobe), 32'd1);
        check_outs("clrc", 8'h0F, 8'hF0, 8'h3C, 1'b1);

`ifndef OPERAND_LOADER_TIMEOUT_EN
        // Throttled source
        thr = '{8'hC3, 8'h5A, 8'hFF, 8'h01};
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = $urandom_range(0, 10);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 8'($urandom), 1'b0);
                check($sformatf("thr.gap_sel%0d", i), 32'(s_sel), 32'(sels[i]));
            end
            cyc(1'b1, thr[i], 1'b0);
            check($sformatf("thr.sel%0d", i), 32'(s_sel), 32'(sels[i]));
            check($sformatf("thr.strobe%0d", i), 32'(s_strobe), 32'd0);
        end
        cyc(1'b0, 8'h00, 1'b0);
        check("thr.strobe", 32'(s_strobe), 32'd1);
        check_outs("thr", 8'hC3, 8'h5A, 8'hFF, 1'b1);
`else
        // Timeout with TIMEOUT_CYCLES = 4
        cyc(1'b1, 8'h21, 1'b0);
        cyc(1'b1, 8'h43, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b0);
            check($sformatf("to.sel%0d", i), 32'(s_sel), 32'(SEL_CNT));
            check($sformatf("to.err%0d", i), 32'(s_err), 32'd0);
        end
        cyc(1'b0, 8'h00, 1'b0);
        check("to.err", 32'(s_err), 32'd1);
        check("to.sel", 32'(s_sel), 32'(SEL_LSB));
        thr = '{8'h65, 8'h87, 8'hA9, 8'h01};
        cyc(1'b1, thr[0], 1'b0);
        cyc(1'b1, thr[1], 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, thr[2], 1'b0);
        check("nto.sel", 32'(s_sel), 32'(SEL_CNT));
        cyc(1'b1, thr[3], 1'b0);
        check("nto.err", 32'(s_err), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        check("nto.strobe", 32'(s_strobe), 32'd1);
        check_outs("nto", 8'h65, 8'h87, 8'hA9, 1'b1);
`endif

        // Reset mid-frame clears committed outputs
        cyc(1'b1, 8'h77, 1'b0);
        cyc(1'b1, 8'h88, 1'b0);
        do_reset();
        cyc(1'b0, 8'h00, 1'b0);
        check("rmid.sel", 32'(s_sel), 32'(SEL_LSB));
        check("rmid.strobe", 32'(s_strobe), 32'd0);
        check_outs("rmid", 8'h00, 8'h00, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/operand_loader.md
# operand_loader

Byte-wide input sequencer for the adder/accumulator datapath; the write-side counterpart of the output mux. Accepts a 4-byte operand frame over a valid/ready handshake and steers each byte into its field: register_2 LSB, register_2 MSB, counter preload value, counter carry preload. Fields are held in staging registers and committed atomically with a one-cycle load strobe. A `sel_out` tag, encoded with the `MUX_SEL_*` codes from `mux_sel.vh`, names the field currently expected.

## Interface
- `TIMEOUT_CYCLES`, 16: idle cycles allowed mid-frame before abort. Used only with `OPERAND_LOADER_TIMEOUT_EN`; legal range 1..255.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `byte_in` input 8: frame byte.
- `byte_valid` input 1: `byte_in` is valid.
- `byte_ready` output 1: loader accepts a byte this cycle. Combinational from state and `frame_clear`.
- `frame_clear` input 1: synchronous abort; discards the partial frame.
- `sel_out` output 3: field expected next, as a `MUX_SEL_*` code.
- `register_2_lsb` output 8: committed register_2 low byte.
- `register_2_msb` output 8: committed register_2 high byte.
- `counter_value` output 8: committed counter preload.
- `counter_carry` output 1: committed carry preload.
- `load_strobe` output 1: one-cycle pulse; committed outputs are new.
- `frame_error` output 1: one-cycle pulse; frame discarded.

## Operation
- States:
  - `S_LSB` (reset/idle): `sel_out`=`MUX_SEL_REGISTER_2_LSB`.
  - `S_MSB`: `sel_out`=`MUX_SEL_REGISTER_2_MSB`.
  - `S_CNT`: `sel_out`=`MUX_SEL_COUNTER_VALUE`.
  - `S_CARRY`: `sel_out`=`MUX_SEL_COUNTER_CARRY`.
  - `S_COMMIT`: `sel_out` holds `MUX_SEL_COUNTER_CARRY`.
- Transfer occurs on a rising edge where `byte_valid && byte_ready`.
- `byte_ready` = 1 in `S_LSB`..`S_CARRY` when `frame_clear`=0; 0 in `S_COMMIT` or when `frame_clear`=1.
- Byte handling per state:
  - `S_LSB`, `S_MSB`, `S_CNT`: a transfer writes the byte into that state's staging register and advances one state.
  - `S_CARRY`: transfer with `byte_in[7:1]`==0 stages bit 0 and goes to `S_COMMIT`.
  - `S_CARRY`: transfer with `byte_in[7:1]`!=0 discards the frame, goes to `S_LSB`, pulses `frame_error` next cycle.
- `S_COMMIT` lasts exactly one cycle, then `S_LSB`. Staging registers copy to the four output fields on the edge entering `S_COMMIT`. `load_strobe`=1 throughout `S_COMMIT`.
- `frame_clear`=1 in any state except `S_COMMIT`:
  - next state `S_LSB`; staging discarded; outputs unchanged; no `frame_error`.
  - In `S_COMMIT` it is ignored; the commit already occurred.
- Absent a transfer, state and staging registers hold.
- Committed outputs change only on entry to `S_COMMIT`.

## Timing
- Reset values: state `S_LSB`, `sel_out`=`MUX_SEL_REGISTER_2_LSB`, all data outputs 0, `load_strobe`=0, `frame_error`=0. `byte_ready`=1 during reset only if `frame_clear`=0; sources must not rely on transfers during reset.
- Reset mid-frame: partial frame lost; outputs return to 0.
- Back-to-back frame: 4 transfer cycles + 1 commit cycle = 5 cycles per frame. Steady-state throughput is 4 bytes per 5 cycles.
- Latency: `load_strobe` and new outputs appear the cycle after the carry byte transfer.
- `frame_error` is registered: asserted the cycle after the offending transfer or timeout. A new `S_LSB` byte may transfer in that same cycle.
- `reset` overrides `frame_clear`; `frame_clear` overrides `byte_valid`.

## Configuration
- Macro: `OPERAND_LOADER_TIMEOUT_EN`.
- Defined:
  - An 8-bit idle counter runs in `S_MSB`, `S_CNT` and `S_CARRY`. It clears on every transfer, on entry to `S_LSB`, and on reset.
  - When it reaches `TIMEOUT_CYCLES` with no transfer: next state `S_LSB`, staging discarded, `frame_error` pulses next cycle.
  - A transfer in the cycle the count is reached wins; no timeout.
- Undefined: no counter. The loader waits indefinitely mid-frame; `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset then bytes 0x34, 0x12, 0x7F, 0x01 back-to-back:
  - `load_strobe` high exactly once, in cycle 5.
  - Outputs `register_2_lsb`=0x34, `register_2_msb`=0x12, `counter_value`=0x7F, `counter_carry`=1.
  - `byte_ready` low only in cycle 5.
- Two consecutive frames (0xAA,0x55,0x10,0x00 then 0x01,0x02,0x03,0x01) with `byte_valid` held high: strobes 5 cycles apart; second frame's values are committed.
- Carry byte 0x02 after 0x11,0x22,0x33:
  - `frame_error` pulse next cycle; no `load_strobe`; outputs keep prior values.
  - `sel_out` returns to `MUX_SEL_REGISTER_2_LSB`.
- `frame_clear` asserted in `S_CNT` coincident with `byte_valid`:
  - byte not accepted; state `S_LSB`; no `frame_error`.
  - A following full frame commits correctly.
- Throttled source (random `byte_valid` gaps up to 10 cycles, macro undefined): the frame commits correctly and `sel_out` tracks each field.
- With `OPERAND_LOADER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4:
  - stall 4 cycles after the MSB byte → `frame_error` pulse, state `S_LSB`.
  - stall of 3 cycles then transfer → no abort.
